// File: rtl/sobel_mem_arb.sv
// sobel_mem_arb: three-way arbiter (host H, sobel read R, sobel write W) for one single-port pixel memory.
// Latency: the grant and the memory command are combinational in the request cycle, and rvalid follows one cycle later.
// Backpressure: requests are level-held until granted; round-robin H->R->W; a host lock holds up to LOCK_MAX extra grants.
//
// Ports:
//   clk_i, rst_i                      clock and synchronous active-high reset
//   h_req_i/h_we_i/h_lock_i/h_addr_i/h_data_i   host request, write select, burst lock, address, data
//   r_req_i/r_addr_i                  sobel read request and pixel address
//   w_req_i/w_addr_i/w_data_i         sobel write request, address, result pixel
//   h_gnt_o/r_gnt_o/w_gnt_o           one-hot (or zero) grants
//   h_rvalid_o/r_rvalid_o/rdata_o     read return, one cycle after a read grant
//   mem_wr_en_o/mem_addr_o/mem_data_o single-port memory command; mem_data_i read data
// Optional build macro SOBEL_ARB_STATS_EN adds the 32-bit saturating counters
// h_cnt_o, r_cnt_o, w_cnt_o (grants) and stall_cnt_o (cycles with an ungranted request).
module sobel_mem_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  h_req_i,
  input  logic                  h_we_i,
  input  logic                  h_lock_i,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic [DATA_WIDTH-1:0] h_data_i,
  input  logic                  r_req_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic                  w_req_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  h_gnt_o,
  output logic                  r_gnt_o,
  output logic                  w_gnt_o,
  output logic                  h_rvalid_o,
  output logic                  r_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
`ifdef SOBEL_ARB_STATS_EN
  ,
  output logic [31:0]           h_cnt_o,
  output logic [31:0]           r_cnt_o,
  output logic [31:0]           w_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    SEL_H = 2'd0,
    SEL_R = 2'd1,
    SEL_W = 2'd2
  } sel_e;

  sel_e                  last_gnt;
  logic [LCW-1:0]        lock_cnt;
  logic                  h_gnt_q;
  logic                  h_rv_q;
  logic                  r_rv_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic h_gnt, r_gnt, w_gnt, any_gnt, lock_win;

  // The host keeps the port only if it held it last cycle and has lock budget left.
  assign lock_win = h_gnt_q & h_lock_i & h_req_i & (lock_cnt < LCW'(LOCK_MAX));

  always_comb begin
    h_gnt = 1'b0;
    r_gnt = 1'b0;
    w_gnt = 1'b0;
    if (!rst_i) begin
      if (lock_win) begin
        h_gnt = 1'b1;
      end else begin
        // Search order starts at the requester after the last winner.
        case (last_gnt)
          SEL_H: begin
            if (r_req_i)      r_gnt = 1'b1;
            else if (w_req_i) w_gnt = 1'b1;
            else if (h_req_i) h_gnt = 1'b1;
          end
          SEL_R: begin
            if (w_req_i)      w_gnt = 1'b1;
            else if (h_req_i) h_gnt = 1'b1;
            else if (r_req_i) r_gnt = 1'b1;
          end
          default: begin
            if (h_req_i)      h_gnt = 1'b1;
            else if (r_req_i) r_gnt = 1'b1;
            else if (w_req_i) w_gnt = 1'b1;
          end
        endcase
      end
    end
  end

  assign any_gnt = h_gnt | r_gnt | w_gnt;

  // Without a grant the memory command holds its last address/data.
  // A sobel read carries no data, so the data bus keeps its previous value.
  always_comb begin
    mem_addr_o = addr_q;
    mem_data_o = data_q;
    if (h_gnt) begin
      mem_addr_o = h_addr_i;
      mem_data_o = h_data_i;
    end else if (r_gnt) begin
      mem_addr_o = r_addr_i;
    end else if (w_gnt) begin
      mem_addr_o = w_addr_i;
      mem_data_o = w_data_i;
    end
  end

  assign mem_wr_en_o = (h_gnt & h_we_i) | w_gnt;
  assign h_gnt_o     = h_gnt;
  assign r_gnt_o     = r_gnt;
  assign w_gnt_o     = w_gnt;

  // Gating with rst_i kills the return of a read granted just before reset.
  assign h_rvalid_o = h_rv_q & ~rst_i;
  assign r_rvalid_o = r_rv_q & ~rst_i;
  assign rdata_o    = mem_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt <= SEL_W;
      lock_cnt <= '0;
      h_gnt_q  <= 1'b0;
      h_rv_q   <= 1'b0;
      r_rv_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      if (h_gnt)      last_gnt <= SEL_H;
      else if (r_gnt) last_gnt <= SEL_R;
      else if (w_gnt) last_gnt <= SEL_W;
      lock_cnt <= lock_win ? lock_cnt + LCW'(1) : '0;
      h_gnt_q  <= h_gnt;
      h_rv_q   <= h_gnt & ~h_we_i;
      r_rv_q   <= r_gnt;
      addr_q   <= mem_addr_o;
      data_q   <= mem_data_o;
    end
  end

`ifdef SOBEL_ARB_STATS_EN
  logic stall;
  assign stall = (h_req_i & ~h_gnt) | (r_req_i & ~r_gnt) | (w_req_i & ~w_gnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_o     <= '0;
      r_cnt_o     <= '0;
      w_cnt_o     <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (h_gnt && h_cnt_o != '1) h_cnt_o <= h_cnt_o + 32'd1;
      if (r_gnt && r_cnt_o != '1) r_cnt_o <= r_cnt_o + 32'd1;
      if (w_gnt && w_cnt_o != '1) w_cnt_o <= w_cnt_o + 32'd1;
      if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_mem_arb.sv
module tb_sobel_mem_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        h_req_i, h_we_i, h_lock_i;
  logic [15:0] h_addr_i;
  logic [7:0]  h_data_i;
  logic        r_req_i;
  logic [15:0] r_addr_i;
  logic        w_req_i;
  logic [15:0] w_addr_i;
  logic [7:0]  w_data_i;
  logic        h_gnt_o, r_gnt_o, w_gnt_o;
  logic        h_rvalid_o, r_rvalid_o;
  logic [7:0]  rdata_o;
  logic        mem_wr_en_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic [7:0]  mem_data_i;
`ifdef SOBEL_ARB_STATS_EN
  logic [31:0] h_cnt_o, r_cnt_o, w_cnt_o, stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];

  sobel_mem_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .LOCK_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .h_req_i(h_req_i), .h_we_i(h_we_i), .h_lock_i(h_lock_i),
    .h_addr_i(h_addr_i), .h_data_i(h_data_i),
    .r_req_i(r_req_i), .r_addr_i(r_addr_i),
    .w_req_i(w_req_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .h_gnt_o(h_gnt_o), .r_gnt_o(r_gnt_o), .w_gnt_o(w_gnt_o),
    .h_rvalid_o(h_rvalid_o), .r_rvalid_o(r_rvalid_o), .rdata_o(rdata_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
`ifdef SOBEL_ARB_STATS_EN
    , .h_cnt_o(h_cnt_o), .r_cnt_o(r_cnt_o), .w_cnt_o(w_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Single-port memory: write on wr_en, registered read one cycle after the address.
  always @(posedge clk_i) begin
    if (mem_wr_en_o) mem[mem_addr_o] <= mem_data_o;
    mem_data_i <= mem[mem_addr_o];
  end

  typedef struct {
    logic        h_req, h_we, h_lock;
    logic [15:0] h_addr;
    logic [7:0]  h_data;
    logic        r_req;
    logic [15:0] r_addr;
    logic        w_req;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic [2:0]  gnt;    // {h,r,w}
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  rv;     // {h_rvalid, r_rvalid}
    logic        chk_rd;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic hq, input logic hwe, input logic [15:0] ha, input logic [7:0] hd,
    input logic rq, input logic [15:0] ra,
    input logic wq, input logic [15:0] wa, input logic [7:0] wd,
    input logic [2:0] g, input logic wr, input logic [15:0] a, input logic [7:0] d,
    input logic [1:0] rv, input logic crd, input logic [7:0] rd);
    vec_t v;
    v.h_req = hq; v.h_we = hwe; v.h_lock = 1'b0; v.h_addr = ha; v.h_data = hd;
    v.r_req = rq; v.r_addr = ra;
    v.w_req = wq; v.w_addr = wa; v.w_data = wd;
    v.gnt = g; v.wr = wr; v.addr = a; v.data = d; v.rv = rv; v.chk_rd = crd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    h_req_i = 0; h_we_i = 0; h_lock_i = 0; h_addr_i = 0; h_data_i = 0;
    r_req_i = 0; r_addr_i = 0; w_req_i = 0; w_addr_i = 0; w_data_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic all_req();
    h_req_i = 1; h_we_i = 0; h_addr_i = 16'h0100; h_data_i = 8'h11;
    r_req_i = 1; r_addr_i = 16'h0200;
    w_req_i = 1; w_addr_i = 16'h0300; w_data_i = 8'h5A;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem_data_i = 8'h00;
    rst_i = 1'b1;
    idle_inputs();

    //                 hq hwe ha       hd     rq ra       wq wa       wd     gnt     wr addr     data   rv     crd rd
    vecs.push_back(mk(1, 0, 16'h0100, 8'h11, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b100, 0, 16'h0100, 8'h11, 2'b00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h0100, 8'h11, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b010, 0, 16'h0200, 8'h11, 2'b10, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h0100, 8'h11, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b001, 1, 16'h0300, 8'h5A, 2'b01, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h0100, 8'h11, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b100, 0, 16'h0100, 8'h11, 2'b00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h0100, 8'h11, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b010, 0, 16'h0200, 8'h11, 2'b10, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h0100, 8'h11, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b001, 1, 16'h0300, 8'h5A, 2'b01, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 3'b000, 0, 16'h0300, 8'h5A, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 1, 16'h0010, 0, 16'h0000, 8'h00, 3'b010, 0, 16'h0010, 8'h5A, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 3'b000, 0, 16'h0010, 8'h5A, 2'b01, 1, 8'hD3));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 16'h0005, 8'hA5, 3'b001, 1, 16'h0005, 8'hA5, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 1, 16'h0005, 0, 16'h0000, 8'h00, 3'b010, 0, 16'h0005, 8'hA5, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 3'b000, 0, 16'h0005, 8'hA5, 2'b01, 1, 8'hA5));
    vecs.push_back(mk(1, 1, 16'h0007, 8'h77, 0, 16'h0000, 0, 16'h0000, 8'h00, 3'b100, 1, 16'h0007, 8'h77, 2'b00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h0007, 8'h77, 0, 16'h0000, 0, 16'h0000, 8'h00, 3'b100, 0, 16'h0007, 8'h77, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b010, 0, 16'h0200, 8'h77, 2'b10, 1, 8'h77));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b001, 1, 16'h0300, 8'h5A, 2'b01, 0, 8'h00));
    vecs.push_back(mk(1, 1, 16'h0100, 8'h22, 1, 16'h0200, 1, 16'h0300, 8'h5A, 3'b100, 1, 16'h0100, 8'h22, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 3'b000, 0, 16'h0100, 8'h22, 2'b00, 0, 8'h00));

    // Reset state.
    do_reset();
    #2;
    chk("rst_gnt", {h_gnt_o, r_gnt_o, w_gnt_o}, 3'b000);
    chk("rst_wr_en", mem_wr_en_o, 1'b0);
    chk("rst_addr", mem_addr_o, 16'h0000);
    chk("rst_data", mem_data_o, 8'h00);
    chk("rst_rvalid", {h_rvalid_o, r_rvalid_o}, 2'b00);

    // Table: one vector per cycle, inputs at negedge, outputs sampled 2 ns later.
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk_i);
      h_req_i = vecs[i].h_req; h_we_i = vecs[i].h_we; h_lock_i = vecs[i].h_lock;
      h_addr_i = vecs[i].h_addr; h_data_i = vecs[i].h_data;
      r_req_i = vecs[i].r_req; r_addr_i = vecs[i].r_addr;
      w_req_i = vecs[i].w_req; w_addr_i = vecs[i].w_addr; w_data_i = vecs[i].w_data;
      #2;
      chk($sformatf("v%0d_gnt", i), {h_gnt_o, r_gnt_o, w_gnt_o}, vecs[i].gnt);
      chk($sformatf("v%0d_wr_en", i), mem_wr_en_o, vecs[i].wr);
      chk($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].addr);
      chk($sformatf("v%0d_data", i), mem_data_o, vecs[i].data);
      chk($sformatf("v%0d_rvalid", i), {h_rvalid_o, r_rvalid_o}, vecs[i].rv);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].rd);
    end

    // Host lock with LOCK_MAX=4: five host grants, then R.
    do_reset();
    h_req_i = 1; h_lock_i = 1; h_addr_i = 16'h0040; r_req_i = 1; r_addr_i = 16'h0041;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge clk_i);
      #2;
      chk($sformatf("lock_c%0d", c), {h_gnt_o, r_gnt_o, w_gnt_o}, (c < 5) ? 3'b100 : (c == 5) ? 3'b010 : 3'b100);
    end

    // Reset right after an R grant suppresses its rvalid; afterwards H wins first.
    do_reset();
    r_req_i = 1; r_addr_i = 16'h0020;
    #2;
    chk("prerst_r_gnt", r_gnt_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #2;
    chk("inrst_r_rvalid", r_rvalid_o, 1'b0);
    chk("inrst_gnt", {h_gnt_o, r_gnt_o, w_gnt_o}, 3'b000);
    chk("inrst_wr_en", mem_wr_en_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    all_req();
    #2;
    chk("postrst_first", {h_gnt_o, r_gnt_o, w_gnt_o}, 3'b100);
    chk("postrst_rvalid", {h_rvalid_o, r_rvalid_o}, 2'b00);

    // Round-robin rerun from reset (also feeds the optional statistics).
    do_reset();
    all_req();
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk_i);
      #2;
      chk($sformatf("rr_c%0d", c), {h_gnt_o, r_gnt_o, w_gnt_o}, 3'b100 >> (c % 3));
    end
    @(negedge clk_i);
    idle_inputs();
    #2;
`ifdef SOBEL_ARB_STATS_EN
    chk("stat_h", h_cnt_o, 32'd2);
    chk("stat_r", r_cnt_o, 32'd2);
    chk("stat_w", w_cnt_o, 32'd2);
    chk("stat_stall", stall_cnt_o, 32'd6);
`endif
    chk("rr_idle_gnt", {h_gnt_o, r_gnt_o, w_gnt_o}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_mem_arb.md
SOBEL_MEM_ARB -- requirements
Module: sobel_mem_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16: pixel memory address width in bits.
REQ-003 Parameter LOCK_MAX, default 16: maximum consecutive host-locked grants.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 h_req_i, h_we_i, h_lock_i  in  1 each  host request, write select, burst lock.
REQ-007 h_addr_i, h_data_i  in  ADDR_WIDTH, DATA_WIDTH  host address and write data.
REQ-008 r_req_i, r_addr_i  in  1, ADDR_WIDTH  sobel read request and pixel address.
REQ-009 w_req_i, w_addr_i, w_data_i  in  1, ADDR_WIDTH, DATA_WIDTH  sobel write request, address, result pixel.
REQ-010 h_gnt_o, r_gnt_o, w_gnt_o  out  1 each  grant, one-hot or all zero.
REQ-011 h_rvalid_o, r_rvalid_o  out  1 each  read data valid for that requester.
REQ-012 rdata_o  out  DATA_WIDTH  read data, shared by host and sobel read.
REQ-013 mem_wr_en_o, mem_addr_o, mem_data_o  out  1, ADDR_WIDTH, DATA_WIDTH  single-port memory command.
REQ-014 mem_data_i  in  DATA_WIDTH  memory read data, valid one cycle after the address.

Function
REQ-015 Arbitration SHALL be combinational: the grant is asserted in the same cycle as the winning request.
REQ-016 Requesters are H, R, W; round-robin order SHALL start from the requester after last_gnt (H->R->W->H).
REQ-017 last_gnt SHALL update to the granted requester on every cycle with a grant; it SHALL hold when there is no grant.
REQ-018 With no request pending, all grants SHALL be 0, mem_wr_en_o 0, and mem_addr_o/mem_data_o hold their previous values.
REQ-019 Mem mux: the granted requester's address SHALL drive mem_addr_o; mem_wr_en_o = (h_gnt_o & h_we_i) | w_gnt_o; mem_data_o = the granted requester's write data.
REQ-020 A read grant (h_gnt_o & ~h_we_i, or r_gnt_o) SHALL assert the matching rvalid exactly one cycle later, with rdata_o = mem_data_i.
REQ-021 rvalid SHALL be a registered single-cycle pulse per grant; back-to-back read grants yield back-to-back pulses.
REQ-022 Host lock: while h_gnt_o was asserted the previous cycle, h_lock_i=1, h_req_i=1 and lock_cnt < LOCK_MAX, H SHALL win regardless of round-robin.
REQ-023 lock_cnt SHALL increment on each locked host grant and clear when the host is not granted or h_lock_i=0.
REQ-024 When lock_cnt reaches LOCK_MAX, the next cycle SHALL use normal round-robin, with last_gnt=H.
REQ-025 Requests SHALL be level-held; a requester deasserting before its grant is dropped without side effects.
REQ-026 A request that is continuously asserted SHALL be granted within 2 cycles when unlocked, and within LOCK_MAX+2 cycles otherwise.

Reset
REQ-027 On rst_i: last_gnt=W (host first), lock_cnt=0, both rvalid outputs 0, mem_addr_o=0, mem_data_o=0.
REQ-028 While rst_i=1, all grants and mem_wr_en_o SHALL be 0.
REQ-029 A read granted in the cycle before reset SHALL produce no rvalid.

Configuration
REQ-030 Macro SOBEL_ARB_STATS_EN defined: add outputs h_cnt_o, r_cnt_o, w_cnt_o (32 bits each) counting grants, plus stall_cnt_o (32 bits) counting cycles with a request pending but not granted; counters saturate at all-ones and clear on rst_i.
REQ-031 Macro undefined: these ports and counters SHALL be absent, and arbitration behaviour SHALL be identical.

Verification
REQ-032 Reset, then R only, r_addr_i=0x0010 -> r_gnt_o same cycle, mem_addr_o=0x0010; next cycle r_rvalid_o=1, rdata_o=mem[0x0010].
REQ-033 H, R, W all held for 6 cycles, no lock -> grant sequence H,R,W,H,R,W; exactly one grant per cycle.
REQ-034 W only, w_addr_i=0x0005, w_data_i=0xA5 -> w_gnt_o=1, mem_wr_en_o=1, mem_data_o=0xA5 in that cycle; a later read of 0x0005 returns 0xA5.
REQ-035 h_lock_i=1 with H and R held continuously, LOCK_MAX=4 -> H granted 5 consecutive cycles (initial grant plus 4 locked grants), then R granted.
REQ-036 rst_i asserted the cycle after an R grant -> no r_rvalid_o; after reset with all requesters held, H is granted first.
REQ-037 With SOBEL_ARB_STATS_EN defined, rerun the REQ-033 stimulus -> h_cnt_o=r_cnt_o=w_cnt_o=2, stall_cnt_o=6.
